// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : Client request/acknowledge bus for the VRAM port B arbiter.
//            master = client side, slave = arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cl_req;
    logic              cl_we;
    logic [ADDR_W-1:0] cl_addr;
    logic [DATA_W-1:0] cl_wdata;
    logic              cl_ack;
    logic              cl_rvalid;
    logic [DATA_W-1:0] cl_rdata;

    modport master (
        output cl_req, cl_we, cl_addr, cl_wdata,
        input  cl_ack, cl_rvalid, cl_rdata
    );

    modport slave (
        input  cl_req, cl_we, cl_addr, cl_wdata,
        output cl_ack, cl_rvalid, cl_rdata
    );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shares VRAM port B between the VGA fetch path (fixed slots,
//            never delayed) and one req/ack client using the free cycles.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 vga_slot,
    input  wire  [ADDR_W-1:0]   vga_addr,
    output logic [DATA_W-1:0]   vga_q,
    vram_arbiter_if.slave       cl,
    input  wire                 stat_clr,
    output logic [15:0]         stall_cnt,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_d,
    output logic                ram_we,
    input  wire  [DATA_W-1:0]   ram_q
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RD_WAIT   = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;
    localparam logic [1:0] c_WAIT_LAST = 2'(RD_LAT - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_wait_cnt;
    logic              r_is_rd;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_stall;
    logic [RD_LAT-1:0] r_vga_sr;
    logic [DATA_W-1:0] r_vga_hold;
    logic              w_issue;
    logic              w_capture;
    logic              w_vga_pipe;

    // Client owns the port only from IDLE, outside reset, in a non-VGA cycle
    assign w_issue   = rst & (r_state == c_IDLE) & cl.cl_req & ~vga_slot;
    assign w_capture = (r_state == c_RD_WAIT) & (r_wait_cnt == c_WAIT_LAST);

    // Port B mux: VGA address by default, client only on its issue cycle
    always_comb begin
        ram_addr = vga_addr;
        ram_d    = '0;
        ram_we   = 1'b0;
        if (w_issue) begin
            ram_addr = cl.cl_addr;
            ram_d    = cl.cl_wdata;
            ram_we   = cl.cl_we;
        end
    end

    // Client transaction FSM: IDLE -> (RD_WAIT) -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= 2'd0;
            r_is_rd    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_issue) begin
                        r_is_rd    <= ~cl.cl_we;
                        r_wait_cnt <= 2'd0;
                        r_state    <= cl.cl_we ? c_DONE : c_RD_WAIT;
                    end
                end
                c_RD_WAIT: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= c_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Read data is captured on the last wait cycle and held until the next read
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= ram_q;
        end
    end

    // Saturating blocked-cycle counter; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall <= 16'd0;
        end else if (stat_clr) begin
            r_stall <= 16'd0;
        end else if ((r_state == c_IDLE) && cl.cl_req && vga_slot && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    // VGA slot delay line lines up vga_slot with the returning ram_q
    generate
        if (RD_LAT == 1) begin : g_pipe_1
            // Single-stage delay
            always_ff @(posedge clk) begin
                if (!rst) r_vga_sr <= '0;
                else      r_vga_sr <= vga_slot;
            end
        end else begin : g_pipe_n
            // Multi-stage delay
            always_ff @(posedge clk) begin
                if (!rst) r_vga_sr <= '0;
                else      r_vga_sr <= {r_vga_sr[RD_LAT-2:0], vga_slot};
            end
        end
    endgenerate

    assign w_vga_pipe = r_vga_sr[RD_LAT-1];

    // Last VGA fetch result, so client reads never show up on vga_q
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vga_hold <= '0;
        end else if (w_vga_pipe) begin
            r_vga_hold <= ram_q;
        end
    end

    assign vga_q        = w_vga_pipe ? ram_q : r_vga_hold;
    assign cl.cl_ack    = (r_state == c_DONE);
    assign cl.cl_rvalid = (r_state == c_DONE) & r_is_rd;
    assign cl.cl_rdata  = r_rdata;
    assign stall_cnt    = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Self-checking bench; RD_LAT=1 and RD_LAT=2 arbiters side by side,
//            each with its own RAM and a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic        vga_slot;
    logic [15:0] vga_addr;
    logic        cl_req;
    logic        cl_we;
    logic [15:0] cl_addr;
    logic [15:0] cl_wdata;
    logic        stat_clr;
    logic        alt_en;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat0;
    int          lat1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = k + 1;

        vram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cl_if ();

        logic [15:0] vga_q_w;
        logic [15:0] ram_addr_w;
        logic [15:0] ram_d_w;
        logic [15:0] ram_q_w;
        logic [15:0] stall_w;
        logic        ram_we_w;
        logic        done    = 1'b0;
        int          ack_cyc = -1;
        int          ack_cnt = 0;
        int          we_cnt  = 0;

        // RAM: unwritten locations read as ~address
        logic [15:0] mem [0:65535];
        bit          wr_mask [0:65535];
        logic [15:0] q1 = '0;
        logic [15:0] q2 = '0;

        // Model state
        bit          model_on   = 1'b0;
        bit          pend_rd    = 1'b0;
        int          ack_at     = -1;
        int          free_at    = 0;
        logic [15:0] pend_rdata = '0;
        logic [15:0] exp_rdata  = '0;
        logic [15:0] exp_stall  = '0;
        logic [15:0] exp_hold   = '0;
        int          due_q [$];
        logic [15:0] dat_q [$];

        function automatic logic [15:0] ram_rd(input logic [15:0] a);
            return wr_mask[a] ? mem[a] : ~a;
        endfunction

        assign cl_if.cl_req   = cl_req & ~done;
        assign cl_if.cl_we    = cl_we;
        assign cl_if.cl_addr  = cl_addr;
        assign cl_if.cl_wdata = cl_wdata;
        assign ram_q_w        = (LAT == 1) ? q1 : q2;

        vram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .vga_slot  (vga_slot),
            .vga_addr  (vga_addr),
            .vga_q     (vga_q_w),
            .cl        (cl_if),
            .stat_clr  (stat_clr),
            .stall_cnt (stall_w),
            .ram_addr  (ram_addr_w),
            .ram_d     (ram_d_w),
            .ram_we    (ram_we_w),
            .ram_q     (ram_q_w)
        );

        always @(posedge clk) begin
            if (ram_we_w === 1'b1) begin
                mem[ram_addr_w]     <= ram_d_w;
                wr_mask[ram_addr_w] <= 1'b1;
            end
            q1 <= ram_rd(ram_addr_w);
            q2 <= q1;
            done <= !cl_req ? 1'b0 : ((cl_if.cl_ack === 1'b1) ? 1'b1 : done);
        end

        always @(negedge clk) begin
            logic issue;
            logic e_ack;
            issue = rst && cl_if.cl_req && !vga_slot && (cyc >= free_at);
            if (cl_if.cl_ack === 1'b1) begin
                ack_cyc = cyc;
                ack_cnt++;
            end
            if (ram_we_w === 1'b1) we_cnt++;
            if (model_on) begin
                chk($sformatf("L%0d ram_addr", LAT), ram_addr_w, issue ? cl_addr : vga_addr);
                chk($sformatf("L%0d ram_d", LAT), ram_d_w, issue ? cl_wdata : 16'h0000);
                chk($sformatf("L%0d ram_we", LAT), 16'(ram_we_w), 16'(issue && cl_we));
                e_ack = (cyc == ack_at);
                if (e_ack && pend_rd) exp_rdata = pend_rdata;
                chk($sformatf("L%0d cl_ack", LAT), 16'(cl_if.cl_ack), 16'(e_ack));
                chk($sformatf("L%0d cl_rvalid", LAT), 16'(cl_if.cl_rvalid), 16'(e_ack && pend_rd));
                chk($sformatf("L%0d cl_rdata", LAT), cl_if.cl_rdata, exp_rdata);
                chk($sformatf("L%0d stall_cnt", LAT), stall_w, exp_stall);
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    exp_hold = dat_q[0];
                    void'(due_q.pop_front());
                    void'(dat_q.pop_front());
                end
                chk($sformatf("L%0d vga_q", LAT), vga_q_w, exp_hold);
            end
            if (!rst) begin
                model_on  = 1'b1;
                pend_rd   = 1'b0;
                ack_at    = -1;
                free_at   = 0;
                exp_rdata = '0;
                exp_stall = '0;
                exp_hold  = '0;
                due_q.delete();
                dat_q.delete();
            end else begin
                if (stat_clr) exp_stall = '0;
                else if (cl_if.cl_req && vga_slot && cyc >= free_at && exp_stall != 16'hFFFF)
                    exp_stall = exp_stall + 16'd1;
                if (issue) begin
                    ack_at     = cyc + (cl_we ? 1 : LAT + 1);
                    free_at    = ack_at + 1;
                    pend_rd    = !cl_we;
                    pend_rdata = ram_rd(cl_addr);
                end
                if (vga_slot) begin
                    due_q.push_back(cyc + LAT);
                    dat_q.push_back(ram_rd(vga_addr));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (alt_en) vga_slot = ~vga_slot;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(g_dut[0].done && g_dut[1].done) && n < 200) begin
            tick();
            n++;
        end
        chk("client op timeout", 16'(n >= 200), 16'd0);
    endtask

    task automatic client_op(input logic we, input logic [15:0] a, input logic [15:0] d);
        int t0;
        cl_we    = we;
        cl_addr  = a;
        cl_wdata = d;
        cl_req   = 1'b1;
        t0       = cyc;
        wait_done();
        lat0   = g_dut[0].ack_cyc - t0;
        lat1   = g_dut[1].ack_cyc - t0;
        cl_req = 1'b0;
        tick();
    endtask

    initial begin
        int w0;
        int w1;
        int a0;
        int a1;
        rst      = 1'b0;
        vga_slot = 1'b0;
        vga_addr = 16'h0100;
        cl_req   = 1'b1;
        cl_we    = 1'b1;
        cl_addr  = 16'h0040;
        cl_wdata = 16'hBEEF;
        stat_clr = 1'b0;
        alt_en   = 1'b0;

        // Reset with a write request pending: nothing may reach the RAM
        repeat (3) tick();
        @(negedge clk);
        chk("reset ack L1", 16'(g_dut[0].cl_if.cl_ack), 16'd0);
        chk("reset ack L2", 16'(g_dut[1].cl_if.cl_ack), 16'd0);
        chk("reset we L1", 16'(g_dut[0].ram_we_w), 16'd0);
        chk("reset we L2", 16'(g_dut[1].ram_we_w), 16'd0);
        chk("reset stall L1", g_dut[0].stall_w, 16'd0);
        chk("reset rdata L2", g_dut[1].cl_if.cl_rdata, 16'd0);
        cl_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Blanking write
        w0 = g_dut[0].we_cnt;
        w1 = g_dut[1].we_cnt;
        client_op(1'b1, 16'h0040, 16'hBEEF);
        chk("write ack lat L1", 16'(lat0), 16'd1);
        chk("write ack lat L2", 16'(lat1), 16'd1);
        chk("write we cycles L1", 16'(g_dut[0].we_cnt - w0), 16'd1);
        chk("write we cycles L2", 16'(g_dut[1].we_cnt - w1), 16'd1);

        // Read-back and read latency
        client_op(1'b0, 16'h0040, 16'h0000);
        chk("readback L1", g_dut[0].cl_if.cl_rdata, 16'hBEEF);
        chk("readback L2", g_dut[1].cl_if.cl_rdata, 16'hBEEF);
        client_op(1'b0, 16'h1234, 16'h0000);
        chk("read lat L1", 16'(lat0), 16'd2);
        chk("read lat L2", 16'(lat1), 16'd3);
        chk("read 1234 L1", g_dut[0].cl_if.cl_rdata, 16'hEDCB);
        chk("read 1234 L2", g_dut[1].cl_if.cl_rdata, 16'hEDCB);

        // VGA fetch then client read next cycle: vga_q keeps the fetch
        vga_slot = 1'b1;
        vga_addr = 16'h5555;
        tick();
        vga_slot = 1'b0;
        vga_addr = 16'h0002;
        client_op(1'b0, 16'hAAAA, 16'h0000);
        chk("vga hold L1", g_dut[0].vga_q_w, 16'hAAAA);
        chk("vga hold L2", g_dut[1].vga_q_w, 16'hAAAA);
        chk("client 5555 L1", g_dut[0].cl_if.cl_rdata, 16'h5555);
        chk("client 5555 L2", g_dut[1].cl_if.cl_rdata, 16'h5555);

        // Active-display contention: request lands in the first free slot
        vga_addr = 16'h0777;
        vga_slot = 1'b1;
        alt_en   = 1'b1;
        client_op(1'b1, 16'h0050, 16'h1357);
        alt_en   = 1'b0;
        vga_slot = 1'b0;
        chk("contention lat L1", 16'(lat0), 16'd2);
        chk("contention lat L2", 16'(lat1), 16'd2);
        chk("contention stall L1", g_dut[0].stall_w, 16'd1);
        chk("contention stall L2", g_dut[1].stall_w, 16'd1);

        // Reset in the middle of a read: abandoned, then re-serviced
        cl_we   = 1'b0;
        cl_addr = 16'h0040;
        cl_req  = 1'b1;
        tick();
        a0  = g_dut[0].ack_cnt;
        a1  = g_dut[1].ack_cnt;
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst rdata L1", g_dut[0].cl_if.cl_rdata, 16'd0);
        chk("midrst rdata L2", g_dut[1].cl_if.cl_rdata, 16'd0);
        chk("midrst stall L1", g_dut[0].stall_w, 16'd0);
        chk("midrst vga_q L2", g_dut[1].vga_q_w, 16'd0);
        tick();
        chk("midrst no ack L1", 16'(g_dut[0].ack_cnt - a0), 16'd0);
        chk("midrst no ack L2", 16'(g_dut[1].ack_cnt - a1), 16'd0);
        rst = 1'b1;
        wait_done();
        chk("midrst retry L1", g_dut[0].cl_if.cl_rdata, 16'hBEEF);
        chk("midrst retry L2", g_dut[1].cl_if.cl_rdata, 16'hBEEF);
        cl_req = 1'b0;
        tick();

        // Long stall: counter saturates, then clears
        vga_slot = 1'b1;
        cl_we    = 1'b0;
        cl_addr  = 16'h0050;
        cl_req   = 1'b1;
        repeat (70000) tick();
        @(negedge clk);
        chk("stall sat L1", g_dut[0].stall_w, 16'hFFFF);
        chk("stall sat L2", g_dut[1].stall_w, 16'hFFFF);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stall clr L1", g_dut[0].stall_w, 16'd0);
        chk("stall clr L2", g_dut[1].stall_w, 16'd0);
        tick();
        vga_slot = 1'b0;
        wait_done();
        chk("post-stall read L1", g_dut[0].cl_if.cl_rdata, 16'h1357);
        chk("post-stall read L2", g_dut[1].cl_if.cl_rdata, 16'h1357);
        cl_req = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Shares port B of the video RAM between the VGA pixel fetch path and one secondary client, such as the CPU bus bridge or a blitter. VGA fetches own every cycle marked by `vga_slot` and are never delayed. The client gets the port with a req/ack handshake in any unreserved cycle. The block sits between the `vga` top (`addr_b`/`q_b`) and the RAM's port B, and is transparent to the VGA path.

## Interface
- `ADDR_W`, default 16: RAM address width.
- `DATA_W`, default 16: RAM data width.
- `RD_LAT`, default 1: RAM port B read latency in cycles, from address presented to `ram_q` valid. Legal values are 1 and 2.

- `clk`  input  1: system clock; sole clock.
- `rst`  input  1: synchronous, active-low reset.
- `vga_slot`  input  1: cycle is reserved for a VGA fetch. Top level ties this to `vga_blank_n & ~vga_clk`.
- `vga_addr`  input  ADDR_W: VGA fetch address.
- `vga_q`  output  DATA_W: VGA read data.
- `cl_req`  input  1: client request; held high until `cl_ack`.
- `cl_we`  input  1: 1 = write, 0 = read. Stable while `cl_req` is high.
- `cl_addr`  input  ADDR_W: client address. Stable while `cl_req` is high.
- `cl_wdata`  input  DATA_W: client write data. Stable while `cl_req` is high.
- `cl_ack`  output  1: one-cycle completion pulse, registered.
- `cl_rvalid`  output  1: one-cycle pulse, coincident with `cl_ack`, for reads only.
- `cl_rdata`  output  DATA_W: read data, registered. Holds its value until the next read completes.
- `stat_clr`  input  1: clears `stall_cnt`.
- `stall_cnt`  output  16: saturating count of cycles the client was blocked.
- `ram_addr`  output  ADDR_W: RAM port B address.
- `ram_d`  output  DATA_W: RAM port B write data.
- `ram_we`  output  1: RAM port B write enable.
- `ram_q`  input  DATA_W: RAM port B read data.

## Operation
- FSM states: IDLE, RD_WAIT, DONE. Reset state is IDLE.
- IDLE:
  - If `cl_req & ~vga_slot`, the client is issued this cycle: `ram_addr=cl_addr`, `ram_d=cl_wdata`, `ram_we=cl_we`.
  - Next state is DONE for a write, RD_WAIT for a read.
  - If `cl_req & vga_slot`, the client is not issued, state stays IDLE, and `stall_cnt` increments.
- RD_WAIT:
  - Lasts exactly RD_LAT cycles, using an internal counter.
  - On its last cycle, `ram_q` is captured into `cl_rdata`.
  - Next state is DONE.
- DONE:
  - `cl_ack=1`; `cl_rvalid=1` if the completed operation was a read.
  - `cl_req` is ignored; next state is IDLE.
- Port mux: in every cycle not issuing a client access, `ram_addr=vga_addr`, `ram_we=0`, `ram_d=0`. VGA therefore also gets all idle cycles. A client issue never occurs in a `vga_slot` cycle.
- VGA data path:
  - `vga_slot` is delayed through an RD_LAT-deep shift register to give `vga_pipe`.
  - `vga_q = vga_pipe ? ram_q : vga_hold`.
  - `vga_hold` loads `ram_q` whenever `vga_pipe=1`.
  - VGA sees zero added latency, and client traffic never disturbs `vga_q` between fetches.
- `stall_cnt`:
  - Increments in IDLE when `cl_req & vga_slot`.
  - Saturates at 16'hFFFF.
  - `stat_clr` has priority over increment, so the count becomes 0 on the next cycle.
- Only one client access is outstanding at a time. No write buffering.

## Timing
- Reset values (`rst=0` at a clock edge):
  - State IDLE; `cl_ack`, `cl_rvalid` = 0.
  - `cl_rdata`, `vga_hold`, `stall_cnt`, shift register, RD_WAIT counter = 0.
  - `ram_we` is gated combinationally and is 0 in any cycle where `rst=0`.
- Write:
  - Issue in cycle T.
  - `cl_ack` is high in T+1.
  - IDLE in T+2.
  - Minimum spacing between back-to-back writes: 2 cycles.
- Read:
  - Issue in cycle T.
  - Capture at the end of T+RD_LAT.
  - `cl_ack`, `cl_rvalid` and `cl_rdata` valid in T+RD_LAT+1.
  - Minimum spacing: RD_LAT+2 cycles.
- Client protocol: the client drops `cl_req`, or changes to the next request, after sampling `cl_ack`. A `cl_req` still high in the first IDLE cycle after DONE is treated as a new request.
- Reset mid-operation:
  - A pending read is abandoned; no ack is produced.
  - A `cl_req` still held after reset is serviced again from IDLE.
- Continuous `vga_slot` high: the client waits indefinitely. This is legal, and `stall_cnt` counts every waiting cycle.

## Test plan
- Blanking write:
  - Stimulus: `vga_slot=0`, write `addr=16'h0040`, `data=16'hBEEF` in cycle T.
  - Required: `ram_we=1` only in T; `cl_ack` in T+1; a later read returns 16'hBEEF.
- Active-display contention:
  - Stimulus: `vga_slot` alternating 1,0; `cl_req` asserted while `vga_slot=1`.
  - Required: the issue lands in the next `vga_slot=0` cycle; `ram_addr` equals `vga_addr` in every slot cycle; `stall_cnt=1`.
- Read latency:
  - Stimulus: RD_LAT=1 and RD_LAT=2 builds; read 16'h1234 issued in cycle T.
  - Required: `cl_rvalid` and `cl_ack` in T+2 and T+3 respectively; `cl_rdata` equals the RAM contents.
- VGA hold:
  - Stimulus: VGA fetch of 16'hAAAA followed by a client read of 16'h5555 in the next cycle.
  - Required: `vga_q` stays 16'hAAAA until the next VGA fetch.
- Reset mid-read:
  - Stimulus: `rst=0` during RD_WAIT.
  - Required: no `cl_ack`, all outputs zero; the held request completes normally after reset.
- Counter:
  - Stimulus: `vga_slot` held high for 70000 cycles with `cl_req` high, then `stat_clr`.
  - Required: `stall_cnt` saturates at 16'hFFFF, then reads 0 the cycle after the clear.
